// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (Booth) / divide (restoring) unit; build option MULTDIV_BOOTH_RADIX4_EN.
// Latency: result pulse 33 cycles after start (multiply 17 with MULTDIV_BOOTH_RADIX4_EN).
// No backpressure: a start in any state aborts the current operation and restarts.
module multdiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

`ifdef MULTDIV_BOOTH_RADIX4_EN
  localparam logic [5:0] MUL_ITER = 6'd16;
`else
  localparam logic [5:0] MUL_ITER = 6'd32;
`endif
  localparam logic [5:0] DIV_ITER = 6'd32;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state;
  logic [5:0]  count;
  // {34-bit accumulator, 32-bit multiplier, Booth guard bit}
  logic [66:0] prod;
  logic [31:0] mcand;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        neg_res;
  logic        div_zero;
  logic        div_ovf;

  logic [33:0] m34;
  logic [33:0] addend;
  logic [33:0] acc_sum;
  logic [66:0] prod_nxt;
  logic        mul_exc;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_res;
  logic        div_exc;

  assign m34 = {{2{mcand[31]}}, mcand};

  always_comb begin
    addend = '0;
`ifdef MULTDIV_BOOTH_RADIX4_EN
    case (prod[2:0])
      3'b001, 3'b010: addend = m34;
      3'b011:         addend = m34 << 1;
      3'b100:         addend = -(m34 << 1);
      3'b101, 3'b110: addend = -m34;
      default:        addend = '0;
    endcase
    acc_sum  = prod[66:33] + addend;
    prod_nxt = {{2{acc_sum[33]}}, acc_sum, prod[32:2]};
`else
    case (prod[1:0])
      2'b01:   addend = m34;
      2'b10:   addend = -m34;
      default: addend = '0;
    endcase
    acc_sum  = prod[66:33] + addend;
    prod_nxt = {acc_sum[33], acc_sum, prod[32:1]};
`endif
  end

  // Final 64-bit product sits at prod[64:1]; overflow when bits 63:31 disagree.
  assign mul_exc = !((&prod[64:32]) || !(|prod[64:32]));

  always_comb begin
    shifted = {rem, quo[31]};
    trial   = shifted - {1'b0, dvs};
    rem_nxt = trial[32] ? shifted[31:0] : trial[31:0];
    quo_nxt = {quo[30:0], ~trial[32]};
  end

  assign mag_a = data_operandA[31] ? -data_operandA : data_operandA;
  assign mag_b = data_operandB[31] ? -data_operandB : data_operandB;

  always_comb begin
    div_res = neg_res ? -quo : quo;
    div_exc = 1'b0;
    if (div_zero) begin
      div_res = '0;
      div_exc = 1'b1;
    end else if (div_ovf) begin
      div_res = 32'h8000_0000;
      div_exc = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      prod           <= '0;
      mcand          <= '0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      neg_res        <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        state <= MUL;
        busy  <= 1'b1;
        count <= '0;
        prod  <= {34'd0, data_operandB, 1'b0};
        mcand <= data_operandA;
      end else if (ctrl_DIV) begin
        state    <= DIV;
        busy     <= 1'b1;
        count    <= '0;
        rem      <= '0;
        quo      <= mag_a;
        dvs      <= mag_b;
        neg_res  <= data_operandA[31] ^ data_operandB[31];
        div_zero <= (data_operandB == 32'd0);
        div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      end else begin
        case (state)
          MUL: begin
            if (count == MUL_ITER) begin
              state          <= DONE;
              busy           <= 1'b0;
              data_resultRDY <= 1'b1;
              data_result    <= prod[32:1];
              data_exception <= mul_exc;
            end else begin
              prod  <= prod_nxt;
              count <= count + 6'd1;
            end
          end
          DIV: begin
            if (count == DIV_ITER) begin
              state          <= DONE;
              busy           <= 1'b0;
              data_resultRDY <= 1'b1;
              data_result    <= div_res;
              data_exception <= div_exc;
            end else begin
              rem   <= rem_nxt;
              quo   <= quo_nxt;
              count <= count + 6'd1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
